// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock divider.
package clk_div_pkg;

    // Reference clock rate feeding every divider channel.
    localparam int CLK_HZ = 50_000_000;

    // Half-period that yields a 1 Hz output from CLK_HZ: 2*(half+1) = CLK_HZ.
    localparam int DEFAULT_HALF_1HZ = CLK_HZ / 2 - 1;

    // Width of the load channel index; covers up to 16 channels.
    localparam int LD_CH_W = 4;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: free-running counter, live and shadow half-period,
// square-wave output and a tick that marks every output edge.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W        = 26,
    parameter int DEFAULT_HALF = DEFAULT_HALF_1HZ
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             ld_i,
    input  logic [CNT_W-1:0] ld_half_i,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic             pend_o
);

    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wrap;

    assign wrap = en_i && (cnt_q >= half_q);

    // Next-state: sync beats everything, a disabled channel idles at zero,
    // a running channel counts and toggles on wrap.
    always_comb begin
        cnt_d    = cnt_q;
        half_d   = half_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        clk_d    = clk_q;
        tick_d   = 1'b0;

        if (sync_i) begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (pend_q) begin
                half_d = shadow_q;
                pend_d = 1'b0;
            end
            // A load coinciding with sync goes straight to the live value.
            if (ld_i) begin
                half_d   = ld_half_i;
                shadow_d = ld_half_i;
            end
        end else if (!en_i) begin
            cnt_d = '0;
            clk_d = 1'b0;
            // Nothing is running, so a parked shadow can be applied at once
            // instead of blocking further loads forever.
            if (pend_q) begin
                half_d = shadow_q;
                pend_d = 1'b0;
            end
            if (ld_i) begin
                half_d   = ld_half_i;
                shadow_d = ld_half_i;
            end
        end else begin
            if (wrap) begin
                cnt_d  = '0;
                clk_d  = ~clk_q;
                tick_d = 1'b1;
                if (pend_q) begin
                    half_d = shadow_q;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            // Loads are only accepted with pend clear, so a load on a wrap
            // cycle is parked and takes effect at the following wrap.
            if (ld_i) begin
                shadow_d = ld_half_i;
                pend_d   = 1'b1;
            end
        end
    end

    // Channel state register with asynchronous reset to the default rate.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            half_q   <= HALF_RST;
            shadow_q <= HALF_RST;
            pend_q   <= 1'b0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
        end
    end

    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;
    assign pend_o    = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Bank of independent clock dividers sharing one reference clock, with a
// common sync restart and a single divisor-load port.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 26,
    parameter int DEFAULT_HALF = DEFAULT_HALF_1HZ
) (
    input  logic               clk_50MHz,
    input  logic               reset,
    input  logic [NUM_CH-1:0]  en,
    input  logic               sync,
    input  logic               load_valid,
    input  logic [LD_CH_W-1:0] load_ch,
    input  logic [CNT_W-1:0]   load_half,
    output logic               load_ready,
    output logic [NUM_CH-1:0]  clk_out,
    output logic [NUM_CH-1:0]  tick,
    output logic [NUM_CH-1:0]  pending
);

    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] pend;
    logic              accept;

    // An index with no matching channel has no hit bit, so it reads as
    // ready and its load is silently dropped.
    assign load_ready = ~|(hit & pend);
    assign accept     = load_valid & load_ready;
    assign pending    = pend;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign hit[i] = (load_ch == LD_CH_W'(i));

        clk_div_ch #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk_i     (clk_50MHz),
            .rst_i     (reset),
            .en_i      (en[i]),
            .sync_i    (sync),
            .ld_i      (accept & hit[i]),
            .ld_half_i (load_half),
            .clk_out_o (clk_out[i]),
            .tick_o    (tick[i]),
            .pend_o    (pend[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

    logic        clk_50MHz = 1'b0;
    logic        reset;
    logic [3:0]  en;
    logic        sync;
    logic        load_valid;
    logic [3:0]  load_ch;
    logic [25:0] load_half;
    logic        load_ready;
    logic [3:0]  clk_out;
    logic [3:0]  tick;
    logic [3:0]  pending;

    int checks = 0;
    int errors = 0;

    clk_div_multi #(
        .NUM_CH       (4),
        .CNT_W        (26),
        .DEFAULT_HALF (4)
    ) dut (
        .clk_50MHz  (clk_50MHz),
        .reset      (reset),
        .en         (en),
        .sync       (sync),
        .load_valid (load_valid),
        .load_ch    (load_ch),
        .load_half  (load_half),
        .load_ready (load_ready),
        .clk_out    (clk_out),
        .tick       (tick),
        .pending    (pending)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    task automatic step();
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        en         = 4'b0000;
        sync       = 1'b0;
        load_valid = 1'b0;
        load_ch    = 4'd0;
        load_half  = 26'd0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        en         = 4'b1111;
        sync       = 1'b0;
        load_valid = 1'b0;
        load_ch    = 4'd0;
        load_half  = 26'd0;
        step();
        step();
        checks++;
        if (clk_out !== 4'b0000) begin
            errors++; $display("FAIL reset_clk_out got %b want 0000", clk_out);
        end
        checks++;
        if (tick !== 4'b0000) begin
            errors++; $display("FAIL reset_tick got %b want 0000", tick);
        end
        checks++;
        if (pending !== 4'b0000) begin
            errors++; $display("FAIL reset_pending got %b want 0000", pending);
        end
        checks++;
        if (load_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b want 1", load_ready);
        end
    endtask

    // Channel 0 at half=4: toggles every 5 cycles, others stay low.
    task automatic test_basic();
        logic [3:0] ec, et;
        do_reset();
        en = 4'b0001;
        for (int n = 1; n <= 20; n++) begin
            step();
            ec = {3'b000, 1'(((n / 5) % 2) == 1)};
            et = {3'b000, 1'((n % 5) == 0)};
            checks++;
            if (clk_out !== ec) begin
                errors++; $display("FAIL basic_clk n=%0d got %b want %b", n, clk_out, ec);
            end
            checks++;
            if (tick !== et) begin
                errors++; $display("FAIL basic_tick n=%0d got %b want %b", n, tick, et);
            end
        end
    endtask

    // Mid-period load to ch0 parks in the shadow until the next wrap.
    task automatic test_load_pending();
        logic [3:0] ec, et;
        do_reset();
        en = 4'b0001;
        step(); step();
        load_valid = 1'b1; load_ch = 4'd0; load_half = 26'd1;
        #1;
        checks++;
        if (load_ready !== 1'b1) begin
            errors++; $display("FAIL load_ready_pre got %b want 1", load_ready);
        end
        step();                                   // edge 3: accepted
        load_valid = 1'b0;
        #1;
        checks++;
        if (pending !== 4'b0001) begin
            errors++; $display("FAIL load_pend_e3 got %b want 0001", pending);
        end
        checks++;
        if (load_ready !== 1'b0) begin
            errors++; $display("FAIL load_ready_busy got %b want 0", load_ready);
        end
        step();                                   // edge 4
        checks++;
        if (pending !== 4'b0001 || clk_out !== 4'b0000) begin
            errors++; $display("FAIL load_e4 got pend=%b clk=%b want 0001/0000", pending, clk_out);
        end
        step();                                   // edge 5: wrap applies shadow
        checks++;
        if (pending !== 4'b0000 || load_ready !== 1'b1) begin
            errors++; $display("FAIL load_e5_clear got pend=%b rdy=%b want 0000/1", pending, load_ready);
        end
        checks++;
        if (clk_out !== 4'b0001 || tick !== 4'b0001) begin
            errors++; $display("FAIL load_e5_edge got clk=%b tick=%b want 0001/0001", clk_out, tick);
        end
        for (int j = 6; j <= 12; j++) begin
            step();
            ec = {3'b000, 1'((((j - 5) / 2) % 2) == 0)};
            et = {3'b000, 1'(((j - 5) % 2) == 0)};
            checks++;
            if (clk_out !== ec || tick !== et) begin
                errors++; $display("FAIL load_period4 e=%0d got clk=%b tick=%b want %b/%b", j, clk_out, tick, ec, et);
            end
        end
    endtask

    // Load to a disabled channel is immediate; half=0 toggles every cycle.
    task automatic test_disabled_load();
        logic [3:0] ec;
        do_reset();
        load_valid = 1'b1; load_ch = 4'd2; load_half = 26'd0;
        #1;
        checks++;
        if (load_ready !== 1'b1) begin
            errors++; $display("FAIL dis_ready got %b want 1", load_ready);
        end
        step();
        load_valid = 1'b0;
        checks++;
        if (pending !== 4'b0000 || clk_out !== 4'b0000) begin
            errors++; $display("FAIL dis_direct got pend=%b clk=%b want 0000/0000", pending, clk_out);
        end
        en = 4'b0100;
        for (int n = 1; n <= 6; n++) begin
            step();
            ec = {1'b0, 1'((n % 2) == 1), 2'b00};
            checks++;
            if (clk_out !== ec || tick !== 4'b0100) begin
                errors++; $display("FAIL dis_half0 n=%0d got clk=%b tick=%b want %b/0100", n, clk_out, tick, ec);
            end
        end
    endtask

    // Two channels at different rates, sync realigns and suppresses a wrap.
    task automatic test_sync();
        logic [3:0] exp_c [6] = '{4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0011, 4'b0001};
        logic [3:0] exp_t [6] = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0010};
        do_reset();
        load_valid = 1'b1; load_ch = 4'd1; load_half = 26'd2;
        step();
        load_valid = 1'b0;
        en = 4'b0011;
        for (int n = 1; n <= 7; n++) step();
        checks++;
        if (clk_out !== 4'b0001) begin
            errors++; $display("FAIL sync_pre got %b want 0001", clk_out);
        end
        sync = 1'b1;
        step();
        sync = 1'b0;
        checks++;
        if (clk_out !== 4'b0000 || tick !== 4'b0000) begin
            errors++; $display("FAIL sync_clear got clk=%b tick=%b want 0000/0000", clk_out, tick);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (clk_out !== exp_c[k] || tick !== exp_t[k]) begin
                errors++; $display("FAIL sync_align k=%0d got clk=%b tick=%b want %b/%b", k + 1, clk_out, tick, exp_c[k], exp_t[k]);
            end
        end
        step(); step();
        checks++;
        if (clk_out !== 4'b0001 || tick !== 4'b0000) begin
            errors++; $display("FAIL sync_k8 got clk=%b tick=%b want 0001/0000", clk_out, tick);
        end
        sync = 1'b1;                              // lands on a ch1 wrap edge
        step();
        sync = 1'b0;
        checks++;
        if (clk_out !== 4'b0000 || tick !== 4'b0000) begin
            errors++; $display("FAIL sync_on_wrap got clk=%b tick=%b want 0000/0000", clk_out, tick);
        end
        step(); step(); step();
        checks++;
        if (clk_out !== 4'b0010 || tick !== 4'b0010) begin
            errors++; $display("FAIL sync_restart got clk=%b tick=%b want 0010/0010", clk_out, tick);
        end
    endtask

    // Reset in the middle of a period with a load parked.
    task automatic test_reset_mid();
        do_reset();
        en = 4'b0001;
        for (int n = 1; n <= 6; n++) step();
        load_valid = 1'b1; load_ch = 4'd0; load_half = 26'd1;
        step();
        load_valid = 1'b0;
        checks++;
        if (pending !== 4'b0001 || clk_out !== 4'b0001) begin
            errors++; $display("FAIL rmid_pre got pend=%b clk=%b want 0001/0001", pending, clk_out);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (clk_out !== 4'b0000 || pending !== 4'b0000 || tick !== 4'b0000) begin
            errors++; $display("FAIL rmid_async got clk=%b pend=%b tick=%b want 0", clk_out, pending, tick);
        end
        step();
        reset = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            step();
            checks++;
            if (clk_out[0] !== 1'(n == 5)) begin
                errors++; $display("FAIL rmid_half4 n=%0d got %b want %b", n, clk_out[0], 1'(n == 5));
            end
        end
    endtask

    // Out-of-range channel index: always ready, nothing changes.
    task automatic test_bad_ch();
        do_reset();
        en = 4'b0001;
        step(); step();
        load_valid = 1'b1; load_ch = 4'd7; load_half = 26'd0;
        #1;
        checks++;
        if (load_ready !== 1'b1) begin
            errors++; $display("FAIL bad_ready got %b want 1", load_ready);
        end
        step();
        load_valid = 1'b0;
        checks++;
        if (pending !== 4'b0000) begin
            errors++; $display("FAIL bad_pend got %b want 0000", pending);
        end
        step();
        checks++;
        if (clk_out !== 4'b0000) begin
            errors++; $display("FAIL bad_e4 got %b want 0000", clk_out);
        end
        step();
        checks++;
        if (clk_out !== 4'b0001 || tick !== 4'b0001) begin
            errors++; $display("FAIL bad_e5 got clk=%b tick=%b want 0001/0001", clk_out, tick);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load_pending();
        test_disabled_load();
        test_sync();
        test_reset_mid();
        test_bad_ch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels, 1..16.
REQ-002 Parameter CNT_W, default 26: counter and half-period width in bits.
REQ-003 Parameter DEFAULT_HALF, default 24_999_999: reset half-period value (1 Hz from 50 MHz).
REQ-004 clk_50MHz  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 en  in  NUM_CH  per-channel enable (level).
REQ-007 sync  in  1  single-cycle pulse; restarts all channels phase-aligned.
REQ-008 load_valid  in  1  divisor-load request.
REQ-009 load_ch  in  4  target channel index.
REQ-010 load_half  in  CNT_W  new half-period value.
REQ-011 load_ready  out  1  load accept indication.
REQ-012 clk_out  out  NUM_CH  divided square wave per channel.
REQ-013 tick  out  NUM_CH  one-cycle pulse per channel at each clk_out edge.
REQ-014 pending  out  NUM_CH  shadow load waiting for the next wrap.

Function
REQ-015 Each channel SHALL hold cnt, half, shadow and pend registers, all CNT_W wide except pend.
REQ-016 An enabled channel SHALL increment cnt each cycle; when cnt >= half, cnt SHALL go to 0 and clk_out SHALL toggle.
REQ-017 Output period SHALL be 2*(half+1) cycles; half=0 SHALL give clk_50MHz/2.
REQ-018 tick[i] SHALL be high for exactly the cycle in which the new clk_out[i] value is first visible, and low otherwise.
REQ-019 en[i]=0 SHALL hold cnt at 0, clk_out[i] at 0 and tick[i] at 0; after en rises, the first toggle SHALL occur half+1 cycles later.
REQ-020 load_ready SHALL equal NOT pend[load_ch] when load_ch < NUM_CH, and SHALL be 1 otherwise.
REQ-021 A load SHALL be accepted on a cycle with load_valid AND load_ready.
REQ-022 An accepted load to an enabled channel SHALL write shadow and set pend.
REQ-023 A pending load SHALL transfer shadow to half on the channel's next wrap edge and clear pend on that same edge, so there are no glitched periods.
REQ-024 An accepted load to a disabled channel SHALL write half directly on the next edge, with pend left 0.
REQ-025 An accepted load with load_ch >= NUM_CH SHALL be discarded with no state change.
REQ-026 When sync=1, every channel SHALL next have cnt=0, clk_out=0 and tick=0, and any pending shadow SHALL be applied to half with pend cleared.
REQ-027 Sync SHALL take priority over a wrap in the same cycle.
REQ-028 A load accepted in the same cycle as sync SHALL write half directly.
REQ-029 A load accepted on the same cycle as a wrap SHALL be applied at the following wrap, not the current one.

Reset
REQ-030 On reset, every channel SHALL set cnt=0, half=DEFAULT_HALF, shadow=DEFAULT_HALF, pend=0, clk_out=0 and tick=0, asynchronously.
REQ-031 Reset SHALL cover all state, including clk_out; no register is initialised by declaration only.
REQ-032 After reset deasserts, an enabled channel SHALL first toggle DEFAULT_HALF+1 cycles later.

Structure
REQ-033 Shared package clk_div_pkg SHALL hold the clock-rate constant CLK_HZ=50_000_000, the DEFAULT_HALF default and the load_ch width constant.
REQ-034 One sub-module clk_div_ch SHALL implement a single channel (cnt, half, shadow, pend, clk_out, tick); clk_div_multi SHALL instantiate it NUM_CH times in a generate loop and do the load decode.
REQ-035 Target size SHALL be about 150-250 RTL lines total.

Verification (DEFAULT_HALF=4, NUM_CH=4 for simulation)
REQ-036 Reset, en=4'b0001 -> clk_out[0] toggles every 5 cycles (period 10), tick[0] is one cycle per edge, and channels 1-3 stay 0.
REQ-037 Load ch0 half=1 mid-period -> pending[0]=1 and load_ready=0 for ch0 until the next wrap, then period is 4 and pending clears on that edge.
REQ-038 Load to disabled ch2 half=0, then en[2]=1 -> clk_out[2] toggles every cycle starting 1 cycle after enable.
REQ-039 Channels running with different half values, sync pulse -> all clk_out=0 next cycle and edges re-align; with sync on a wrap cycle the wrap is suppressed.
REQ-040 Reset asserted mid-period with a load pending -> all outputs 0 immediately, half returns to 4, pending=0.
REQ-041 load_ch=7 with load_valid -> load_ready=1 and no channel's behaviour changes.
